// File: rtl/gray_step_tracker_pkg.sv
// Shared definitions for the Gray position tracker: FSM encodings and Gray width.
package gray_step_tracker_pkg;

    localparam int GRAY_W = 3;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_e;

endpackage

// File: rtl/gray_step_tracker_gray2bin.sv
// Combinational 3-bit reflected Gray to binary converter.
module gray2bin
    import gray_step_tracker_pkg::*;
(
    input  logic [GRAY_W-1:0] gray_i,
    output logic [GRAY_W-1:0] bin_o
);

    always_comb begin
        bin_o[2] = gray_i[2];
        bin_o[1] = gray_i[2] ^ gray_i[1];
        bin_o[0] = gray_i[2] ^ gray_i[1] ^ gray_i[0];
    end

endmodule

// File: rtl/gray_step_tracker.sv
// Tracks a 3-bit Gray position: emits up/down step pulses, counts revolutions,
// and latches into FAULT on any non-adjacent jump until cleared.
module gray_step_tracker
    import gray_step_tracker_pkg::*;
#(
    parameter int REV_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [GRAY_W-1:0] gray_in,
    input  logic              clr_fault,
    output logic [GRAY_W-1:0] bin_out,
    output logic              pos_valid,
    output logic              step,
    output logic              dir,
    output logic              err,
    output logic              fault,
    output logic [REV_W-1:0]  rev_count
);

    state_e              state_q, state_d;
    logic [GRAY_W-1:0]   bin_q, bin_d;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic                err_q, err_d;
    logic [REV_W-1:0]    rev_q, rev_d;

    logic [GRAY_W-1:0]   bin_new;
    logic [GRAY_W-1:0]   diff;

    gray2bin u_gray2bin (
        .gray_i (gray_in),
        .bin_o  (bin_new)
    );

    // Modulo-8 distance decides the move: 1 = up, 7 = down, 0 = hold, else illegal.
    assign diff = bin_new - bin_q;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        err_d   = 1'b0;
        rev_d   = rev_q;
        case (state_q)
            INIT: begin
                if (en) begin
                    bin_d   = bin_new;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (en) begin
                    case (diff)
                        3'd0: ;
                        3'd1: begin
                            step_d = 1'b1;
                            dir_d  = 1'b1;
                            bin_d  = bin_new;
                            if (bin_q == 3'd7) rev_d = rev_q + 1'b1;
                        end
                        3'd7: begin
                            step_d = 1'b1;
                            dir_d  = 1'b0;
                            bin_d  = bin_new;
                            if (bin_q == 3'd0) rev_d = rev_q - 1'b1;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = FAULT;
                        end
                    endcase
                end
            end
            FAULT: begin
                // A sample arriving with the clear is dropped; INIT re-acquires later.
                if (clr_fault) state_d = INIT;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            bin_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
            rev_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            rev_q   <= rev_d;
        end
    end

    assign bin_out   = bin_q;
    assign pos_valid = (state_q == TRACK);
    assign fault     = (state_q == FAULT);
    assign step      = step_q;
    assign dir       = dir_q;
    assign err       = err_q;
    assign rev_count = rev_q;

endmodule
